// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// State encoding and default detector pattern live here so RTL and bench agree.
package seq_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] DEF_PAT_0110 = 4'b0110;

  // Counter width able to index 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Start handshake and serial output bundle of the pattern transmitter.
// master = requester / observer side, slave = transmitter side.
interface seq_pattern_gen_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               start_valid;
  logic               start_ready;
  logic [PAT_LEN-1:0] pattern;
  logic [CNT_W-1:0]   repeat_cnt;
  logic               abort;
  logic               sout;
  logic               sout_valid;
  logic               frame_start;
  logic               busy;
  logic               done;

  modport master (
    output start_valid, pattern, repeat_cnt, abort,
    input  start_ready, sout, sout_valid, frame_start, busy, done
  );

  modport slave (
    input  start_valid, pattern, repeat_cnt, abort,
    output start_ready, sout, sout_valid, frame_start, busy, done
  );
endinterface

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register. Shifting rotates the MSB back into
// the LSB so the stored pattern survives for the next repetition.
module seq_piso #(
  parameter int PAT_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [PAT_LEN-1:0] din,
  output logic               q_msb
);

  logic [PAT_LEN-1:0] q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[PAT_LEN-2:0], q[PAT_LEN-1]};
    end
  end

  assign q_msb = q[PAT_LEN-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: accepts a pattern and repeat count, shifts it out
// MSB-first R times with GAP_LEN idle bit-times between repetitions.
module seq_pattern_gen
  import seq_pattern_gen_pkg::*;
#(
  parameter int PAT_LEN  = 4,
  parameter int CNT_W    = 8,
  parameter int GAP_LEN  = 2,
  parameter bit IDLE_BIT = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  seq_pattern_gen_if.slave bus
);

  localparam int BIT_W = cnt_width(PAT_LEN);
  localparam int GAP_W = cnt_width(GAP_LEN);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_LEN == 0) ? 0 : GAP_LEN - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t             state, state_d;
  logic [BIT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [CNT_W-1:0]   rep_cnt;
  logic               accept, last_bit, more_reps, gap_end, new_frame;
  logic               sout_d, sout_valid_d, frame_start_d, busy_d, done_d;
  logic               q_msb;

  assign bus.start_ready = (state == ST_IDLE) && !bus.abort;
  assign accept          = bus.start_valid && bus.start_ready;
  assign last_bit        = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
  assign gap_end         = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  assign more_reps       = rep_cnt > ONE;

  // Loaded pre-rotated by one: the first bit goes straight to sout on accept,
  // so q_msb always holds the bit due on the following edge.
  seq_piso #(.PAT_LEN(PAT_LEN)) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (state_d == ST_SHIFT),
    .din   ({bus.pattern[PAT_LEN-2:0], bus.pattern[PAT_LEN-1]}),
    .q_msb (q_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // NOTE: every always_comb output gets a default first; a path that leaves
  // a variable unassigned would infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (bus.abort)    state_d = ST_IDLE;
        else if (last_bit) begin
          if (!more_reps)       state_d = ST_IDLE;
          else if (GAP_LEN > 0) state_d = ST_GAP;
          else                  state_d = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (bus.abort)    state_d = ST_IDLE;
        else if (gap_end) state_d = ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    new_frame     = accept || ((state_d == ST_SHIFT) && (last_bit || gap_end));
    sout_valid_d  = (state_d == ST_SHIFT);
    busy_d        = (state_d != ST_IDLE);
    frame_start_d = new_frame;
    done_d        = last_bit && !more_reps && !bus.abort;
    sout_d        = IDLE_BIT;
    if (accept)                    sout_d = bus.pattern[PAT_LEN-1];
    else if (state_d == ST_SHIFT)  sout_d = q_msb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt         <= '0;
      gap_cnt         <= '0;
      rep_cnt         <= ONE;
      bus.sout        <= IDLE_BIT;
      bus.sout_valid  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      if (accept)                 bit_cnt <= '0;
      else if (state == ST_SHIFT) bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);

      if (state == ST_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
      else                 gap_cnt <= '0;

      // A zero request still sends one frame; decrement stops at 1.
      if (accept)                       rep_cnt <= (bus.repeat_cnt == '0) ? ONE : bus.repeat_cnt;
      else if (last_bit && more_reps)   rep_cnt <= rep_cnt - ONE;

      bus.sout        <= sout_d;
      bus.sout_valid  <= sout_valid_d;
      bus.frame_start <= frame_start_d;
      bus.busy        <= busy_d;
      bus.done        <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: two instances (GAP_LEN=2 and GAP_LEN=0) share
// stimulus; each is compared per cycle against a queued expected waveform.
module tb_seq_pattern_gen;
  import seq_pattern_gen_pkg::*;

  localparam int PAT_LEN = 4;
  localparam int CNT_W   = 8;

  typedef struct packed {
    logic sout;
    logic valid;
    logic fs;
    logic busy;
    logic done;
  } exp_t;

  localparam exp_t IDLE_EXP = '{sout: 1'b1, valid: 1'b0, fs: 1'b0, busy: 1'b0, done: 1'b0};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  seq_pattern_gen_if #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) bus0 ();
  seq_pattern_gen_if #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) bus1 ();

  seq_pattern_gen #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W), .GAP_LEN(2), .IDLE_BIT(1'b1)) dut_gap2 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );
  seq_pattern_gen #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W), .GAP_LEN(0), .IDLE_BIT(1'b1)) dut_gap0 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  logic [4:0] obs [2];
  logic       rdy [2];
  assign obs[0] = {bus0.sout, bus0.sout_valid, bus0.frame_start, bus0.busy, bus0.done};
  assign obs[1] = {bus1.sout, bus1.sout_valid, bus1.frame_start, bus1.busy, bus1.done};
  assign rdy[0] = bus0.start_ready;
  assign rdy[1] = bus1.start_ready;

  // Expected output tuple for each upcoming cycle, per instance.
  exp_t mq [2][$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  // R repetitions of the pattern, MSB first, gaps between, then a done cycle.
  task automatic push_frames(input int d, input logic [PAT_LEN-1:0] pat, input logic [CNT_W-1:0] rc);
    int reps;
    int gap;
    exp_t e;
    reps = (rc == 0) ? 1 : int'(rc);
    gap  = (d == 0) ? 2 : 0;
    for (int r = 0; r < reps; r++) begin
      for (int b = 0; b < PAT_LEN; b++) begin
        e = '{sout: pat[PAT_LEN-1-b], valid: 1'b1, fs: (b == 0), busy: 1'b1, done: 1'b0};
        mq[d].push_back(e);
      end
      if (r != reps - 1) begin
        for (int g = 0; g < gap; g++) begin
          e = '{sout: 1'b1, valid: 1'b0, fs: 1'b0, busy: 1'b1, done: 1'b0};
          mq[d].push_back(e);
        end
      end
    end
    e = '{sout: 1'b1, valid: 1'b0, fs: 1'b0, busy: 1'b0, done: 1'b1};
    mq[d].push_back(e);
  endtask

  // One clock cycle: entered just after a rising edge.
  task automatic do_cycle(input logic sv, input logic [PAT_LEN-1:0] pat,
                          input logic [CNT_W-1:0] rc, input logic ab);
    exp_t e;
    logic idle;
    logic acc;
    for (int d = 0; d < 2; d++) begin
      e = (mq[d].size() != 0) ? mq[d][0] : IDLE_EXP;
      check($sformatf("dut%0d outputs cyc%0d", d, cyc), 32'(obs[d]), 32'(e));
    end
    bus0.start_valid = sv; bus0.pattern = pat; bus0.repeat_cnt = rc; bus0.abort = ab;
    bus1.start_valid = sv; bus1.pattern = pat; bus1.repeat_cnt = rc; bus1.abort = ab;
    #1;
    for (int d = 0; d < 2; d++) begin
      idle = (mq[d].size() == 0) || !mq[d][0].busy;
      check($sformatf("dut%0d start_ready cyc%0d", d, cyc), 32'(rdy[d]), 32'(idle && !ab));
      acc = sv && idle && !ab;
      if (ab && !idle) begin
        mq[d].delete();
      end else begin
        if (mq[d].size() != 0) void'(mq[d].pop_front());
        if (acc) push_frames(d, pat, rc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [PAT_LEN-1:0] pat;
    logic [CNT_W-1:0]   rc;
    bus0.start_valid = 1'b0; bus0.pattern = '0; bus0.repeat_cnt = '0; bus0.abort = 1'b0;
    bus1.start_valid = 1'b0; bus1.pattern = '0; bus1.repeat_cnt = '0; bus1.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs dut0", 32'(obs[0]), 32'(IDLE_EXP));
    check("reset outputs dut1", 32'(obs[1]), 32'(IDLE_EXP));
    rst_n = 1'b1;

    // Single 0110 frame, then three repetitions with gaps.
    do_cycle(1'b1, DEF_PAT_0110, 8'd1, 1'b0);
    idle_cycles(6);
    do_cycle(1'b1, DEF_PAT_0110, 8'd3, 1'b0);
    idle_cycles(18);

    // Abort on the second bit, and abort while idle blocks a start.
    do_cycle(1'b1, 4'b1011, 8'd2, 1'b0);
    do_cycle(1'b0, '0, '0, 1'b0);
    do_cycle(1'b0, '0, '0, 1'b1);
    do_cycle(1'b1, 4'b1111, 8'd1, 1'b1);
    idle_cycles(3);

    // repeat_cnt=0 with start held high: one frame, re-accept only when done.
    for (int i = 0; i < 14; i++) do_cycle(1'b1, DEF_PAT_0110, 8'd0, 1'b0);
    idle_cycles(12);

    // Two back-to-back repetitions; contiguous on the GAP_LEN=0 instance.
    do_cycle(1'b1, DEF_PAT_0110, 8'd2, 1'b0);
    idle_cycles(12);

    // Asynchronous reset at the third bit of a frame.
    do_cycle(1'b1, DEF_PAT_0110, 8'd3, 1'b0);
    idle_cycles(2);
    rst_n = 1'b0;
    #1;
    check("async reset dut0", 32'(obs[0]), 32'(IDLE_EXP));
    check("async reset dut1", 32'(obs[1]), 32'(IDLE_EXP));
    mq[0].delete();
    mq[1].delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 3000; i++) begin
      pat = PAT_LEN'($urandom);
      rc  = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 20)) : CNT_W'($urandom_range(0, 3));
      do_cycle(1'($urandom_range(0, 1)), pat, rc, ($urandom_range(0, 39) == 0));
    end
    idle_cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
